// File: rtl/serial_word_receiver_pkg.sv
// Shared types and helpers for the serial word receiver
// and the rotating-register family.
package serial_word_receiver_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_word_receiver_word_out_buffer.sv
// Single-entry valid/ready holding register; flags a load that
// arrives while the entry is full and not draining.
module word_out_buffer #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_drop
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;
    logic         valid_q;
    logic         valid_d;
    logic         load_ok;

    always_comb begin
        load_ok = i_load && (!valid_q || i_ready);
        o_drop  = i_load && valid_q && !i_ready;
        data_d  = data_q;
        valid_d = valid_q;
        if (load_ok) begin
            data_d  = i_data;
            valid_d = 1'b1;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel receiver: MSB-first bits framed by i_sof,
// delivered through a one-entry valid/ready buffer.
module serial_word_receiver
    import serial_word_receiver_pkg::*;
#(
    parameter int MSB = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_sdata,
    input  logic           i_svalid,
    input  logic           i_sof,
    output logic [MSB-1:0] o_dout,
    output logic           o_dvalid,
    input  logic           i_dready,
    output logic           o_busy,
    output logic           o_frame_err,
    output logic           o_overrun
);

    localparam int CW = cnt_width(MSB);
    localparam logic [CW-1:0] CNT_LAST = CW'(MSB - 1);

    state_e         state_q;
    state_e         state_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic [MSB-1:0] sreg_q;
    logic [MSB-1:0] sreg_d;
    logic           frame_err_q;
    logic           frame_err_d;
    logic           overrun_q;
    logic           overrun_d;
    logic           word_done;
    logic           drop;
    logic           last_bit;

    assign last_bit = i_svalid && !i_sof && (cnt_q == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sreg_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sreg_q      <= sreg_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (i_svalid && i_sof) state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A start bit always restarts the count, discarding any partial word.
    always_comb begin
        cnt_d       = cnt_q;
        sreg_d      = sreg_q;
        frame_err_d = 1'b0;
        word_done   = 1'b0;
        if (i_svalid && i_sof) begin
            sreg_d      = {sreg_q[MSB-2:0], i_sdata};
            cnt_d       = CW'(1);
            frame_err_d = (state_q == ST_SHIFT);
        end else if (i_svalid && state_q == ST_SHIFT) begin
            sreg_d = {sreg_q[MSB-2:0], i_sdata};
            if (cnt_q == CNT_LAST) begin
                cnt_d     = '0;
                word_done = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        overrun_d = overrun_q || drop;
    end

    word_out_buffer #(
        .W(MSB)
    ) u_buf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (word_done),
        .i_data  (sreg_d),
        .i_ready (i_dready),
        .o_data  (o_dout),
        .o_valid (o_dvalid),
        .o_drop  (drop)
    );

    assign o_busy      = (state_q == ST_SHIFT);
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Randomized and directed bench for serial_word_receiver,
// checked against a bit-queue reference model.
module tb_serial_word_receiver;

    localparam int MSB = 4;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic           i_sdata = 1'b0;
    logic           i_svalid = 1'b0;
    logic           i_sof = 1'b0;
    logic           i_dready = 1'b0;
    logic [MSB-1:0] o_dout;
    logic           o_dvalid;
    logic           o_busy;
    logic           o_frame_err;
    logic           o_overrun;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    bit             m_in_word;
    int             m_nbits;
    int             m_acc;
    logic [MSB-1:0] m_dout;
    bit             m_valid;
    bit             m_fe;
    bit             m_ovr;

    always #5 i_clk = ~i_clk;

    serial_word_receiver #(.MSB(MSB)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_sdata     (i_sdata),
        .i_svalid    (i_svalid),
        .i_sof       (i_sof),
        .o_dout      (o_dout),
        .o_dvalid    (o_dvalid),
        .i_dready    (i_dready),
        .o_busy      (o_busy),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_word = 0;
        m_nbits = 0;
        m_acc = 0;
        m_dout = '0;
        m_valid = 0;
        m_fe = 0;
        m_ovr = 0;
    endtask

    task automatic model_step(input bit v, input bit s, input bit d, input bit r);
        bit done = 0;
        bit drain = m_valid && r;
        m_fe = 0;
        if (v && s) begin
            m_fe = m_in_word;
            m_in_word = 1;
            m_nbits = 1;
            m_acc = int'(d);
        end else if (v && m_in_word) begin
            m_acc = m_acc * 2 + int'(d);
            m_nbits++;
            if (m_nbits == MSB) begin
                done = 1;
                m_in_word = 0;
            end
        end
        if (done) begin
            if (!m_valid || r) begin
                m_valid = 1;
                m_dout = MSB'(m_acc);
            end else begin
                m_ovr = 1;
            end
        end else if (drain) begin
            m_valid = 0;
        end
    endtask

    task automatic check_all();
        chk("dout", 32'(o_dout), 32'(m_dout));
        chk("dvalid", 32'(o_dvalid), 32'(m_valid));
        chk("busy", 32'(o_busy), 32'(m_in_word));
        chk("frame_err", 32'(o_frame_err), 32'(m_fe));
        chk("overrun", 32'(o_overrun), 32'(m_ovr));
    endtask

    task automatic cyc(input bit v, input bit s, input bit d, input bit r);
        @(negedge i_clk);
        i_rst = 1'b0;
        i_svalid = v;
        i_sof = s;
        i_sdata = d;
        i_dready = r;
        model_step(v, s, d, r);
        @(posedge i_clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        i_svalid = 1'b0;
        i_sof = 1'b0;
        @(posedge i_clk);
        #1;
        model_reset();
        chk("rst_dout", 32'(o_dout), 32'h0);
        chk("rst_dvalid", 32'(o_dvalid), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_fe", 32'(o_frame_err), 32'h0);
        chk("rst_ovr", 32'(o_overrun), 32'h0);
    endtask

    task automatic send_word(input logic [MSB-1:0] w, input bit r, input bit r_last,
                             input int gap);
        for (int i = MSB - 1; i >= 0; i--) begin
            cyc(1'b1, i == MSB - 1, w[i], (i == 0) ? r_last : r);
            if (i != 0)
                for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, r);
        end
    endtask

    initial begin
        int busy_cycles;
        model_reset();
        do_reset();

        // Back-to-back bits, consumer always ready
        busy_cycles = 0;
        for (int i = 3; i >= 0; i--) begin
            cyc(1'b1, i == 3, 4'b1011 >> i, 1'b1);
            if (o_busy) busy_cycles++;
        end
        chk("t1_dout", 32'(o_dout), 32'hb);
        chk("t1_dvalid", 32'(o_dvalid), 32'h1);
        chk("t1_busy_cycles", 32'(busy_cycles), 32'd3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_dvalid_drop", 32'(o_dvalid), 32'h0);

        // Stray bit in IDLE, then gapped bits
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("t2_stray_busy", 32'(o_busy), 32'h0);
        send_word(4'b1011, 1'b1, 1'b1, 2);
        chk("t2_dout", 32'(o_dout), 32'hb);
        chk("t2_dvalid", 32'(o_dvalid), 32'h1);

        // Overrun while the consumer stalls
        do_reset();
        send_word(4'b1100, 1'b0, 1'b0, 0);
        send_word(4'b0011, 1'b0, 1'b0, 0);
        chk("t3_dout", 32'(o_dout), 32'hc);
        chk("t3_ovr", 32'(o_overrun), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_drained", 32'(o_dvalid), 32'h0);
        chk("t3_dout_kept", 32'(o_dout), 32'hc);

        // Completion coinciding with consumption
        do_reset();
        send_word(4'b1001, 1'b0, 1'b0, 0);
        send_word(4'b0110, 1'b0, 1'b1, 0);
        chk("t4_dout", 32'(o_dout), 32'h6);
        chk("t4_dvalid", 32'(o_dvalid), 32'h1);
        chk("t4_ovr", 32'(o_overrun), 32'h0);

        // Frame error mid-word
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t5_fe", 32'(o_frame_err), 32'h1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("t5_fe_once", 32'(o_frame_err), 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("t5_dout", 32'(o_dout), 32'h7);

        // Reset mid-word
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        send_word(4'b1010, 1'b1, 1'b1, 0);
        chk("t6_dout", 32'(o_dout), 32'ha);
        chk("t6_dvalid", 32'(o_dvalid), 32'h1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
                    1'($urandom), $urandom_range(0, 9) < 6);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
